// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the forwarding scoreboard
package cpu_types_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_W-1:0] regbits_t;

    // One in-flight instruction as seen by the forwarding tracker.
    typedef struct packed {
        logic     valid;
        regbits_t dest;
        logic     RegWrite;
        logic     MemRead;
    } fwd_entry_t;

    // Countdown counters are at least 3 bits wide even for short latencies.
    function automatic int cnt_width(input int lat);
        int w;
        w = $clog2(lat + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// rtl/forwarding_scoreboard_if.sv - decode-side bundle for the forwarding scoreboard
//  fs modport: scoreboard view (decode fields in, selects/stall out)
//  tb modport: driver view (decode fields out, selects/stall in)
interface forwarding_scoreboard_if
    import cpu_types_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
);
    logic             dec_valid;
    regbits_t         dec_rs;
    regbits_t         dec_rt;
    logic             dec_use_rs;
    logic             dec_use_rt;
    regbits_t         dec_rd;
    logic             dec_RegWrite;
    logic             dec_MemRead;
    logic             dec_long;
    logic             flush;
    logic             mem_wait;
    logic [SEL_W-1:0] forward_a;
    logic [SEL_W-1:0] forward_b;
    logic             stall;
    logic             long_busy;

    modport fs (
        input  dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt, dec_rd,
               dec_RegWrite, dec_MemRead, dec_long, flush, mem_wait,
        output forward_a, forward_b, stall, long_busy
    );

    modport tb (
        output dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt, dec_rd,
               dec_RegWrite, dec_MemRead, dec_long, flush, mem_wait,
        input  forward_a, forward_b, stall, long_busy
    );
endinterface

// File: rtl/scoreboard_counters.sv
// rtl/scoreboard_counters.sv - per-register countdown counters for the multi-cycle unit
//  CLK, nRST        clock, asynchronous active-low reset
//  load, load_reg   start a LONG_LAT countdown on load_reg (register 0 ignored)
//  busy_vec         bit r set while counter r is nonzero
//  long_busy        any counter nonzero
module scoreboard_counters
    import cpu_types_pkg::*;
#(
    parameter int LONG_LAT = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                load,
    input  regbits_t            load_reg,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                long_busy
);

    localparam int               CNT_W    = cnt_width(LONG_LAT);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LONG_LAT);

    logic [CNT_W-1:0] cnt [NUM_REGS];

    // Counters run regardless of pipeline freezes; a fresh load overrides the decrement.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (load && load_reg == regbits_t'(r))
                    cnt[r] <= LOAD_VAL;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
            cnt[0] <= '0;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) busy_vec[r] = (cnt[r] != '0);
    end

    assign long_busy = |busy_vec;

endmodule

// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - forwarding select, load-use stall and long-op scoreboard
//  CLK, nRST                    clock, asynchronous active-low reset
//  dec_*                        decode-stage instruction fields
//  flush                        squash the decode instruction
//  mem_wait                     whole pipeline frozen
//  forward_a/forward_b          0=regfile, k=forward from tracker stage k
//  stall                        hold fetch/decode, bubble into EX
//  long_busy                    any scoreboard counter nonzero
module forwarding_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int LONG_LAT  = 4,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             dec_valid,
    input  regbits_t         dec_rs,
    input  regbits_t         dec_rt,
    input  logic             dec_use_rs,
    input  logic             dec_use_rt,
    input  regbits_t         dec_rd,
    input  logic             dec_RegWrite,
    input  logic             dec_MemRead,
    input  logic             dec_long,
    input  logic             flush,
    input  logic             mem_wait,
    output logic [SEL_W-1:0] forward_a,
    output logic [SEL_W-1:0] forward_b,
    output logic             stall,
    output logic             long_busy
);

    fwd_entry_t            entry [1:FWD_DEPTH];
    fwd_entry_t            ins_entry;
    logic [NUM_REGS-1:0]   busy_vec;
    logic                  use_a, use_b;
    logic                  load_use, raw_long, waw_long, struct_long;
    logic                  insert, cnt_load;

    assign use_a = dec_use_rs && (dec_rs != '0);
    assign use_b = dec_use_rt && (dec_rt != '0);

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        forward_a = '0;
        forward_b = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (entry[k].valid && entry[k].RegWrite) begin
                if (use_a && entry[k].dest == dec_rs) forward_a = SEL_W'(k);
                if (use_b && entry[k].dest == dec_rt) forward_b = SEL_W'(k);
            end
        end
    end

    assign load_use    = entry[1].valid && entry[1].MemRead && (entry[1].dest != '0) &&
                         ((use_a && entry[1].dest == dec_rs) ||
                          (use_b && entry[1].dest == dec_rt));
    assign raw_long    = (use_a && busy_vec[dec_rs]) || (use_b && busy_vec[dec_rt]);
    assign waw_long    = (dec_RegWrite || dec_long) && busy_vec[dec_rd];
    assign struct_long = dec_long && long_busy;

    assign stall = dec_valid && !flush && (load_use || raw_long || waw_long || struct_long);

    assign insert = dec_valid && !stall && !flush;

    // Long ops never forward from the pipeline; their result arrives via the regfile.
    always_comb begin
        ins_entry          = '0;
        ins_entry.valid    = 1'b1;
        ins_entry.dest     = dec_rd;
        ins_entry.RegWrite = dec_RegWrite && !dec_long;
        ins_entry.MemRead  = dec_MemRead && !dec_long;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 1; k <= FWD_DEPTH; k++) entry[k] <= '0;
        end else if (!mem_wait) begin
            for (int k = FWD_DEPTH; k >= 2; k--) entry[k] <= entry[k-1];
            entry[1] <= insert ? ins_entry : '0;
        end
    end

    assign cnt_load = insert && dec_long && !mem_wait && (dec_rd != '0);

    scoreboard_counters #(.LONG_LAT(LONG_LAT)) u_counters (
        .CLK       (CLK),
        .nRST      (nRST),
        .load      (cnt_load),
        .load_reg  (dec_rd),
        .busy_vec  (busy_vec),
        .long_busy (long_busy)
    );

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - self-checking bench for forwarding_scoreboard
module tb_forwarding_scoreboard;
    import cpu_types_pkg::*;

    localparam int LAT = 4;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       dec_valid, dec_use_rs, dec_use_rt, dec_RegWrite, dec_MemRead, dec_long;
    logic       flush, mem_wait;
    regbits_t   dec_rs, dec_rt, dec_rd;
    logic [1:0] fa2, fb2, fa3, fb3;
    logic       stall2, stall3, busy2, busy3;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    forwarding_scoreboard #(.FWD_DEPTH(2), .LONG_LAT(LAT)) dut2 (
        .CLK(CLK), .nRST(nRST), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_rd(dec_rd),
        .dec_RegWrite(dec_RegWrite), .dec_MemRead(dec_MemRead), .dec_long(dec_long),
        .flush(flush), .mem_wait(mem_wait), .forward_a(fa2), .forward_b(fb2),
        .stall(stall2), .long_busy(busy2));

    forwarding_scoreboard #(.FWD_DEPTH(3), .LONG_LAT(LAT)) dut3 (
        .CLK(CLK), .nRST(nRST), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_rd(dec_rd),
        .dec_RegWrite(dec_RegWrite), .dec_MemRead(dec_MemRead), .dec_long(dec_long),
        .flush(flush), .mem_wait(mem_wait), .forward_a(fa3), .forward_b(fb3),
        .stall(stall3), .long_busy(busy3));

    // Reference model: list of recent instructions per depth, plain integer counters.
    int dep [2] = '{2, 3};
    int m_v [2][4];
    int m_dest [2][4];
    int m_fw [2][4];
    int m_ld [2][4];
    int m_cnt [32];
    int e_fa [2];
    int e_fb [2];
    int e_stall, e_busy;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                m_v[d][k] = 0; m_dest[d][k] = 0; m_fw[d][k] = 0; m_ld[d][k] = 0;
            end
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    endtask

    task automatic model_outputs();
        int ra, rb, hazard;
        ra = (dec_use_rs && dec_rs != 0) ? int'(dec_rs) : -1;
        rb = (dec_use_rt && dec_rt != 0) ? int'(dec_rt) : -1;
        for (int d = 0; d < 2; d++) begin
            e_fa[d] = 0;
            e_fb[d] = 0;
            for (int k = 1; k <= dep[d]; k++) begin
                if (m_v[d][k] != 0 && m_fw[d][k] != 0) begin
                    if (e_fa[d] == 0 && m_dest[d][k] == ra) e_fa[d] = k;
                    if (e_fb[d] == 0 && m_dest[d][k] == rb) e_fb[d] = k;
                end
            end
        end
        e_busy = 0;
        for (int r = 0; r < 32; r++) if (m_cnt[r] > 0) e_busy = 1;
        hazard = 0;
        if (m_v[0][1] != 0 && m_ld[0][1] != 0 && m_dest[0][1] != 0 &&
            (m_dest[0][1] == ra || m_dest[0][1] == rb)) hazard = 1;
        if (ra > 0 && m_cnt[ra] > 0) hazard = 1;
        if (rb > 0 && m_cnt[rb] > 0) hazard = 1;
        if ((dec_RegWrite || dec_long) && m_cnt[dec_rd] > 0) hazard = 1;
        if (dec_long && e_busy != 0) hazard = 1;
        e_stall = (dec_valid && !flush && hazard != 0) ? 1 : 0;
    endtask

    task automatic eval();
        @(negedge CLK);
        model_outputs();
        chk("fwd_a_d2", int'(fa2), e_fa[0]);
        chk("fwd_b_d2", int'(fb2), e_fb[0]);
        chk("fwd_a_d3", int'(fa3), e_fa[1]);
        chk("fwd_b_d3", int'(fb3), e_fb[1]);
        chk("stall_d2", int'(stall2), e_stall);
        chk("stall_d3", int'(stall3), e_stall);
        chk("busy_d2", int'(busy2), e_busy);
        chk("busy_d3", int'(busy3), e_busy);
    endtask

    task automatic adv();
        int ins, ld;
        @(posedge CLK);
        if (nRST) begin
            ins = (dec_valid && e_stall == 0 && !flush) ? 1 : 0;
            ld  = (ins != 0 && dec_long && !mem_wait && dec_rd != 0) ? 1 : 0;
            for (int r = 0; r < 32; r++) begin
                if (ld != 0 && r == int'(dec_rd)) m_cnt[r] = LAT;
                else if (m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
            end
            if (!mem_wait) begin
                for (int d = 0; d < 2; d++) begin
                    for (int k = dep[d]; k >= 2; k--) begin
                        m_v[d][k] = m_v[d][k-1]; m_dest[d][k] = m_dest[d][k-1];
                        m_fw[d][k] = m_fw[d][k-1]; m_ld[d][k] = m_ld[d][k-1];
                    end
                    m_v[d][1]    = ins;
                    m_dest[d][1] = int'(dec_rd);
                    m_fw[d][1]   = (dec_RegWrite && !dec_long) ? 1 : 0;
                    m_ld[d][1]   = (dec_MemRead && !dec_long) ? 1 : 0;
                end
            end
        end
        #1;
        nRST = 1'b1;
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input int rd, input logic rw, input logic mr,
                         input logic lg, input logic fl, input logic mw);
        dec_valid = v; dec_rs = regbits_t'(rs); dec_rt = regbits_t'(rt);
        dec_use_rs = urs; dec_use_rt = urt; dec_rd = regbits_t'(rd);
        dec_RegWrite = rw; dec_MemRead = mr; dec_long = lg; flush = fl; mem_wait = mw;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            eval(); adv();
        end
    endtask

    initial begin
        model_clear();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset state
        eval();
        chk("rst_fa", int'(fa2), 0); chk("rst_fb", int'(fb2), 0);
        chk("rst_stall", int'(stall2), 0); chk("rst_busy", int'(busy2), 0);
        adv();

        // add $3 ; add $4,$3,$3 -> stage 1 on both operands
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); eval(); adv();
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0); eval();
        chk("t2_fa1", int'(fa2), 1); chk("t2_fb1", int'(fb2), 1); chk("t2_fa1_d3", int'(fa3), 1);
        adv();

        // add $3 ; filler ; consumer -> stage 2
        bubbles(3);
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); eval(); adv();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); eval(); adv();
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0); eval();
        chk("t2_fa2", int'(fa2), 2); chk("t2_fb2", int'(fb2), 2);
        adv();

        // Two fillers: only the three-deep tracker still sees the producer
        bubbles(3);
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); eval(); adv();
        bubbles(2);
        drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0); eval();
        chk("d3_fa3", int'(fa3), 3); chk("d3_fa_d2_none", int'(fa2), 0);
        adv();

        // lw $5 ; sub $6,$5,$1 -> one stall then forward from stage 2
        bubbles(3);
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); eval(); adv();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0); eval();
        chk("t3_stall", int'(stall2), 1);
        adv();
        eval();
        chk("t3_nostall", int'(stall2), 0); chk("t3_fa", int'(fa2), 2); chk("t3_fb", int'(fb2), 0);
        adv();

        // mult $7 ; add $8,$7,$0 -> four stall cycles
        bubbles(3);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0); eval(); adv();
        drive(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("t4_stall", int'(stall2), 1); chk("t4_busy", int'(busy2), 1);
            adv();
        end
        eval();
        chk("t4_release", int'(stall2), 0); chk("t4_fa", int'(fa2), 0); chk("t4_idle", int'(busy2), 0);
        adv();

        // $9 in stage 1 and stage 2 -> youngest wins
        bubbles(3);
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0); eval(); adv();
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0); eval(); adv();
        drive(1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0); eval();
        chk("t5_fa", int'(fa2), 1); chk("t5_fa_d3", int'(fa3), 1);
        adv();

        // mem_wait freeze with load in stage 1, then flush, then rs=0
        bubbles(3);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); eval(); adv();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); eval(); adv();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 0, 1, 1, 6, 1, 0, 0, 0, 1); eval();
            chk("t6_frozen_stall", int'(stall2), 1);
            adv();
        end
        drive(1, 5, 0, 1, 1, 6, 1, 0, 0, 1, 0); eval();
        chk("t6_flush", int'(stall2), 0);
        adv();
        drive(1, 5, 0, 1, 1, 6, 1, 0, 0, 0, 0); eval();
        chk("t6_fa", int'(fa2), 2); chk("t6_fb_r0", int'(fb3), 0); chk("t6_stall", int'(stall2), 0);
        adv();

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) < 80, $urandom_range(7), $urandom_range(7),
                  $urandom_range(1), $urandom_range(1), $urandom_range(7),
                  $urandom_range(99) < 70, $urandom_range(99) < 25,
                  $urandom_range(99) < 10, $urandom_range(99) < 8,
                  $urandom_range(99) < 15);
            if ($urandom_range(199) == 0) begin
                nRST = 1'b0;
                model_clear();
            end
            eval();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
